cdb_arbiter: RTL and testbench

- Parametrised completion/writeback arbiter between the functional units and the ROB/CDB.
- Replaces the unarbitrated OR-merge of FU result buses.
- Each FU channel gets a small result queue with valid/ready backpressure.
- A round-robin arbiter drains one queued result per cycle onto a single registered completion bus. That bus feeds the ROB and the CDB broadcast.

---
 rtl/cdb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result FIFOs drained round-robin onto one registered completion bus.
// Optional macro CDB_ARB_PERF_EN adds per-channel saturating stall counters on port stall_count.
module cdb_arbiter #(
  parameter int FU_COUNT    = 8,
  parameter int QUEUE_DEPTH = 2,
  parameter int ROBID_BITS  = 4,
  parameter int PREG_BITS   = 4,
  parameter int FLAG_BITS   = 8,
  parameter int DATA_BITS   = 8,
  localparam int CH_BITS    = $clog2(FU_COUNT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FU_COUNT-1:0]               fu_valid,
  output logic [FU_COUNT-1:0]               fu_ready,
  input  logic [FU_COUNT*ROBID_BITS-1:0]    fu_robid,
  input  logic [FU_COUNT*2*PREG_BITS-1:0]   fu_wbs,
  input  logic [FU_COUNT*FLAG_BITS-1:0]     fu_flags,
  input  logic [FU_COUNT*DATA_BITS-1:0]     fu_value,
  input  logic                              flush,
  output logic                              out_valid,
  output logic [ROBID_BITS-1:0]             out_robid,
  output logic [2*PREG_BITS-1:0]            out_wbs,
  output logic [FLAG_BITS-1:0]              out_flags,
  output logic [DATA_BITS-1:0]              out_value,
  output logic [CH_BITS-1:0]                out_chan
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [FU_COUNT*16-1:0]            stall_count
`endif
);

  localparam int WBS_BITS = 2 * PREG_BITS;
  localparam int EW       = ROBID_BITS + WBS_BITS + FLAG_BITS + DATA_BITS;
  localparam int PW       = $clog2(QUEUE_DEPTH);
  localparam int CW       = PW + 1;
  localparam logic [CW-1:0]      FULL_CNT = CW'(QUEUE_DEPTH);
  localparam logic [CH_BITS-1:0] LAST_CH  = CH_BITS'(FU_COUNT - 1);

  logic [EW-1:0]      mem [FU_COUNT][QUEUE_DEPTH];
  logic [CW-1:0]      count [FU_COUNT];
  logic [PW-1:0]      rd_ptr [FU_COUNT];
  logic [PW-1:0]      wr_ptr [FU_COUNT];
  logic [EW-1:0]      in_entry [FU_COUNT];
  logic [FU_COUNT-1:0] nonempty;
  logic [FU_COUNT-1:0] push;
  logic [FU_COUNT-1:0] pop;
  logic [CH_BITS-1:0] ptr;
  logic [CH_BITS-1:0] grant_idx;
  logic [CH_BITS-1:0] cand_idx;
  logic               grant_valid;
  logic [EW-1:0]      head;
  int                 cand;

  // Ready depends only on registered occupancy and reset.
  always_comb begin
    fu_ready = '0;
    nonempty = '0;
    for (int i = 0; i < FU_COUNT; i++) begin
      fu_ready[i] = (count[i] != FULL_CNT) && !rst;
      nonempty[i] = (count[i] != '0);
      in_entry[i] = {fu_robid[i*ROBID_BITS +: ROBID_BITS], fu_wbs[i*WBS_BITS +: WBS_BITS],
                     fu_flags[i*FLAG_BITS +: FLAG_BITS], fu_value[i*DATA_BITS +: DATA_BITS]};
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= FU_COUNT; k++) begin
      cand        = (int'(ptr) + k) % FU_COUNT;
      cand_idx    = CH_BITS'(cand);
      grant_idx   = (!grant_valid && nonempty[cand_idx]) ? cand_idx : grant_idx;
      grant_valid = grant_valid | nonempty[cand_idx];
    end
  end

  // Handshake and grant decode into per-channel push/pop strobes.
  always_comb begin
    push = fu_valid & fu_ready;
    pop  = '0;
    if (grant_valid) begin
      pop[grant_idx] = 1'b1;
    end else begin
      pop = '0;
    end
    head = mem[grant_idx][rd_ptr[grant_idx]];
  end

  // Queue pointers and occupancy; flush empties every queue and drops same-edge pushes.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < FU_COUNT; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FU_COUNT; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PW'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PW'(1);
        end
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Queue storage writes; entries are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FU_COUNT; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= in_entry[i];
      end
    end
  end

  // Registered completion bus and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_robid <= '0;
      out_wbs   <= '0;
      out_flags <= '0;
      out_value <= '0;
      out_chan  <= '0;
      ptr       <= LAST_CH;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        {out_robid, out_wbs, out_flags, out_value} <= head;
        out_chan <= grant_idx;
        ptr      <= grant_idx;
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  // Stall counters saturate and survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else begin
      for (int i = 0; i < FU_COUNT; i++) begin
        if (fu_valid[i] && !fu_ready[i] && (stall_count[i*16 +: 16] != 16'hFFFF)) begin
          stall_count[i*16 +: 16] <= stall_count[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-based reference model feeds expectations, a monitor compares.
module tb_cdb_arbiter;
  localparam int N  = 8;
  localparam int QD = 2;

  typedef struct packed {
    logic [3:0] robid;
    logic [7:0] wbs;
    logic [7:0] flags;
    logic [7:0] value;
  } ent_t;
  typedef struct packed {
    logic [2:0] chan;
    ent_t       e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [N-1:0] fu_valid = '0;
  logic [N-1:0] fu_ready;
  logic [N*4-1:0] fu_robid;
  logic [N*8-1:0] fu_wbs;
  logic [N*8-1:0] fu_flags;
  logic [N*8-1:0] fu_value;
  logic         out_valid;
  logic [3:0]   out_robid;
  logic [7:0]   out_wbs;
  logic [7:0]   out_flags;
  logic [7:0]   out_value;
  logic [2:0]   out_chan;

  ent_t pend [N];
  ent_t mq [N][$];
  exp_t sb [$];
  logic [N-1:0] acc = '0;
  logic last_rst = 1'b0;
  int   mptr = N - 1;
  int   checks = 0;
  int   errors = 0;

  cdb_arbiter #(.FU_COUNT(N), .QUEUE_DEPTH(QD), .ROBID_BITS(4), .PREG_BITS(4),
                .FLAG_BITS(8), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_robid(fu_robid), .fu_wbs(fu_wbs), .fu_flags(fu_flags), .fu_value(fu_value),
    .flush(flush), .out_valid(out_valid), .out_robid(out_robid), .out_wbs(out_wbs),
    .out_flags(out_flags), .out_value(out_value), .out_chan(out_chan));

  always #5 clk = ~clk;

  always_comb begin
    fu_robid = '0;
    fu_wbs   = '0;
    fu_flags = '0;
    fu_value = '0;
    for (int i = 0; i < N; i++) begin
      fu_robid[i*4 +: 4] = pend[i].robid;
      fu_wbs[i*8 +: 8]   = pend[i].wbs;
      fu_flags[i*8 +: 8] = pend[i].flags;
      fu_value[i*8 +: 8] = pend[i].value;
    end
  end

  // Reference model: one FIFO per channel, first non-empty channel after the last grant wins.
  always @(posedge clk) begin
    logic [N-1:0] rdy;
    bit found;
    int c;
    for (int i = 0; i < N; i++) begin
      rdy[i] = (mq[i].size() < QD) && !rst;
      acc[i] = fu_valid[i] && rdy[i];
    end
    last_rst = rst;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      mptr = N - 1;
    end else if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
    end else begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (mptr + k) % N;
        if (!found && mq[c].size() > 0) begin
          found = 1'b1;
          sb.push_back({3'(c), mq[c].pop_front()});
          mptr = c;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) mq[i].push_back(pend[i]);
      end
    end
  end

  // Monitor: ready against model occupancy, completions against the scoreboard.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    logic exp_rdy;
    for (int i = 0; i < N; i++) begin
      exp_rdy = (mq[i].size() < QD) && !rst;
      checks++;
      if (fu_ready[i] !== exp_rdy) begin
        errors++;
        $display("FAIL ready ch%0d @%0t: got %b expected %b", i, $time, fu_ready[i], exp_rdy);
      end
    end
    got = {out_chan, out_robid, out_wbs, out_flags, out_value};
    if (last_rst) begin
      checks++;
      if (out_valid !== 1'b0 || got !== '0) begin
        errors++;
        $display("FAIL reset_out @%0t: got valid=%b bus=%h expected valid=0 bus=0", $time, out_valid, got);
      end
    end else if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out @%0t: got chan=%0d bus=%h expected no output", $time, out_chan, got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL completion @%0t: got chan=%0d entry=%h expected chan=%0d entry=%h",
                   $time, got.chan, got.e, want.chan, want.e);
        end
      end
    end else if (sb.size() != 0) begin
      checks++;
      errors++;
      want = sb.pop_front();
      $display("FAIL missing_out @%0t: got valid=%b expected chan=%0d entry=%h", $time, out_valid, want.chan, want.e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) fu_valid[i] = 1'b0;
    end
  endtask

  task automatic offer(input int ch, input ent_t e);
    pend[ch] = e;
    fu_valid[ch] = 1'b1;
  endtask

  function automatic ent_t rnd();
    logic [31:0] r;
    r = $urandom;
    return r[27:0];
  endfunction

  task automatic offer_rand(input logic [N-1:0] mask, input int pct);
    for (int i = 0; i < N; i++) begin
      if (mask[i] && !fu_valid[i] && ($urandom_range(0, 99) < pct)) offer(i, rnd());
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int sent0;
    int guard;
    for (int i = 0; i < N; i++) pend[i] = '0;
    tick();
    tick();
    rst = 1'b0;

    // single result on channel 2
    offer(2, {4'd3, 8'h21, 8'h00, 8'h5A});
    idle(4);

    // fairness: channels 0, 1, 5 each get two entries
    offer(0, {4'd1, 8'h10, 8'h01, 8'hA0});
    offer(1, {4'd2, 8'h11, 8'h02, 8'hA1});
    offer(5, {4'd4, 8'h15, 8'h03, 8'hA5});
    tick();
    offer(0, {4'd5, 8'h20, 8'h04, 8'hB0});
    offer(1, {4'd6, 8'h21, 8'h05, 8'hB1});
    offer(5, {4'd7, 8'h25, 8'h06, 8'hB5});
    idle(9);

    // backpressure: 20 ordered tags on channel 0 competing with channel 1
    sent0 = 0;
    guard = 0;
    while ((sent0 < 20 || fu_valid[0]) && guard < 400) begin
      if (!fu_valid[0] && sent0 < 20) begin
        offer(0, {4'(sent0), 8'h00, 8'h0F, 8'(sent0)});
        sent0++;
      end
      offer_rand(8'b0000_0010, 100);
      tick();
      guard++;
    end
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("FAIL backpressure_timeout: got %0d pushes offered expected 20 accepted", sent0);
    end
    fu_valid = '0;
    idle(6);

    // flush with entries on 0, 1, 3 and a concurrent push on 4
    offer(0, rnd()); offer(1, rnd()); offer(3, rnd());
    tick();
    offer(0, rnd()); offer(1, rnd()); offer(3, rnd());
    tick();
    offer(4, {4'd9, 8'hEE, 8'hEE, 8'hEE});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fu_valid = '0;
    tick();
    offer(4, {4'd10, 8'h44, 8'h44, 8'h44});
    idle(5);

    // random traffic with occasional flush
    for (int k = 0; k < 400; k++) begin
      offer_rand('1, 40);
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0;

    // reset in the middle of saturated traffic
    for (int k = 0; k < 6; k++) begin
      offer_rand('1, 100);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      offer_rand('1, 70);
      tick();
    end

    // drain
    guard = 0;
    while ((fu_valid != '0 || sb.size() != 0 || mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()
            + mq[4].size() + mq[5].size() + mq[6].size() + mq[7].size() != 0) && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    checks++;
    if (guard >= 100 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations after %0d cycles expected 0", sb.size(), guard);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
